// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port (a - b via ~b and carry-in 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_ovf;

  logic             w_accept, w_last, w_bit, w_maj, w_c_load;
  logic [WIDTH-1:0] w_b_load, w_acc_next;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH-1));

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : c_in;
`else
  assign w_b_load = b;
  assign w_c_load = c_in;
`endif

  assign w_bit      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_maj      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_acc_next = WIDTH'({w_bit, r_acc} >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Visible result only moves at accept (clear) and at DONE entry; r_acc is the working copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_maj;
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_maj;
        r_ovf  <= r_carry ^ w_maj;
      end
    end
  end

  assign sum      = r_sum;
  assign c_out    = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected results queued at drive time, popped on done.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       c_in = 1'b0;
  logic       sub = 1'b0;
  logic       busy, done, c_out, overflow;
  logic [7:0] sum;

  int   n_chk = 0, n_pass = 0, cyc = 0;
  exp_t sb[$];

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb_);
    logic [7:0] yy;
    logic       cc;
    logic [8:0] full;
    logic [7:0] low;
    exp_t       e;
    yy   = sb_ ? ~y : y;
    cc   = sb_ ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {8'b0, cc};
    low  = {1'b0, x[6:0]} + {1'b0, yy[6:0]} + {7'b0, cc};
    e.s  = full[7:0];
    e.co = full[8];
    e.ov = low[7] ^ full[8];
    return e;
  endfunction

  // Result checker: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done && !reset) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", sum, e.s);
        chk("c_out", c_out, e.co);
        chk("overflow", overflow, e.ov);
      end
    end
  end

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin t = cyc; break; end
    end
    if (t < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic ts, input exp_t e);
    int  nb;
    bit  got;
    @(negedge clk);
    a = ta; b = tb_; c_in = tc; sub = ts; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_; c_in = ~tc; sub = ~ts;
    chk("run_sum_clear", sum, 0);
    nb = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy) nb++;
      if (done) got = 1;
      else @(negedge clk);
    end
    chk("busy_cycles", nb, 8);
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("sum_hold", sum, e.s);
    sub = 1'b0;
  endtask

  initial begin
    int t1, t2;
    logic [7:0] ra, rb;
    logic       rc;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_ovf", overflow, 0);

    run_op(8'h3C, 8'h05, 1'b0, 1'b0, '{s: 8'h41, co: 1'b0, ov: 1'b0});
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, '{s: 8'h01, co: 1'b1, ov: 1'b0});
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, '{s: 8'h80, co: 1'b0, ov: 1'b1});

    // Back-to-back with start held; operands change during RUN.
    @(negedge clk);
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    sb.push_back('{s: 8'h30, co: 1'b0, ov: 1'b0});
    @(negedge clk);
    a = 8'h01; b = 8'h01;
    sb.push_back('{s: 8'h02, co: 1'b0, ov: 1'b0});
    wait_done(t1);
    @(negedge clk);
    chk("b2b_reaccept", busy, 1);
    start = 1'b0; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
    wait_done(t2);
    chk("b2b_spacing", t2 - t1, 9);
    @(negedge clk);

    // Reset in the middle of RUN discards the operation.
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", c_out, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    run_op(8'h12, 8'h34, 1'b1, 1'b0, '{s: 8'h47, co: 1'b0, ov: 1'b0});

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, '{s: 8'hFE, co: 1'b0, ov: 1'b0});
    run_op(8'h80, 8'h01, 1'b0, 1'b1, '{s: 8'h7F, co: 1'b1, ov: 1'b1});
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rc, 1'b1, model(ra, rb, rc, 1'b1));
    end
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial ripple adder: adds two `WIDTH`-bit operands LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. It is the clocked successor to the lab half/full adder cells. It trades latency for area and gives a start/busy/done handshake for use by lab datapaths and testbenches. An optional subtract mode is compiled in by macro.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a new operation; sampled only in IDLE or DONE.
- `a`  input  WIDTH  operand A; sampled on the accepting edge only.
- `b`  input  WIDTH  operand B; sampled on the accepting edge only.
- `c_in`  input  1  carry-in; sampled on the accepting edge only.
- `sub`  input  1  subtract select; present only with `SERIAL_ADDER_SUB_EN`.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse when the result becomes valid.
- `sum`  output  WIDTH  result; held until the next accepted start.
- `c_out`  output  1  carry out of the MSB; held with `sum`.
- `overflow`  output  1  two's-complement overflow, equal to carry into MSB XOR `c_out`; held with `sum`.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN: processes one bit per cycle; `start` is ignored.
  - DONE: lasts one cycle.
- Accepting edge (IDLE or DONE with `start`=1):
  - Load shift registers with `a` and `b`.
  - Carry flip-flop loads `c_in`.
  - Bit counter loads 0.
  - Result register clears.
  - State goes to RUN.
- RUN, each edge:
  - sum bit = a0 ^ b0 ^ carry.
  - carry <= majority(a0, b0, carry).
  - Operand registers shift right by 1.
  - Sum bit shifts into the MSB of the result register.
  - Counter increments.
- On the edge where the counter reaches WIDTH-1:
  - Capture carry-in-to-MSB for `overflow`.
  - State goes to DONE.
- DONE:
  - `done`=1.
  - With `start`=1, this is an accepting edge (back-to-back operations).
  - Otherwise the state goes to IDLE.
- Arithmetic: `sum` = (a + b + c_in) mod 2^WIDTH; `c_out` = bit WIDTH of the full sum.
- `busy` = (state == RUN). `done` = (state == DONE). Both are registered-state decodes, so there is no combinational path from inputs.
- `sum`, `c_out` and `overflow` change only at DONE entry and at the clear on an accepting edge. Outside those edges they are stable.

## Timing
- Reset values (asynchronous; applies immediately, including mid-RUN): state=IDLE, `busy`=0, `done`=0, `sum`=0, `c_out`=0, `overflow`=0. All internal registers are 0. The operation in flight is discarded.
- Latency:
  - `start` accepted at edge 0.
  - `busy`=1 after edges 0..WIDTH-1.
  - `done`=1 for the single cycle after edge WIDTH.
  - Result is valid from edge WIDTH onward.
- Throughput: one operation per WIDTH+1 cycles with `start` held high.
- `start` during RUN has no effect, and operands are not re-sampled.
- Operand changes after the accepting edge do not affect the result.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - Port `sub` exists.
  - With `sub`=1 on the accepting edge, B loads as ~`b`, carry loads 1 and `c_in` is ignored.
  - Result `sum` = (a - b) mod 2^WIDTH.
  - `c_out`=1 means no borrow (a ≥ b unsigned).
  - `overflow` = signed overflow of the subtraction.
  - With `sub`=0, behaviour is identical to add mode.
- Not defined: no `sub` port; add only.

## Test plan
- WIDTH=8, a=0x3C, b=0x05, c_in=0, start one cycle → `busy` high 8 cycles; `done` pulse after edge 8; sum=0x41, c_out=0, overflow=0.
- a=0xFF, b=0x01, c_in=1 → sum=0x01, c_out=1, overflow=0.
- a=0x7F, b=0x01, c_in=0 → sum=0x80, c_out=0, overflow=1.
- `start` held high, operands 0x10+0x20 then 0x01+0x01 → done pulses 9 cycles apart; sums 0x30 then 0x02; operand changes during RUN have no effect.
- reset asserted at RUN cycle 4 → all outputs 0 immediately; IDLE; no `done` pulse; next start works normally.
- `SERIAL_ADDER_SUB_EN`, sub=1, a=0x05, b=0x07 → sum=0xFE, c_out=0, overflow=0; a=0x80, b=0x01 → sum=0x7F, c_out=1, overflow=1.
